// File: rtl/trng_pkg.sv
// Shared constants and helpers for the von Neumann debiasing byte packer.
package trng_pkg;

  // Width of one packed output byte.
  localparam int unsigned BYTE_W = 8;

  // Default run length of identical raw bits that trips the health test.
  localparam int unsigned RPT_LIMIT_DEF = 32;

  // Raw bit pairs {first, second} that produce a debiased output bit.
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  // Counter width able to represent the value 'limit' itself.
  function automatic int unsigned rep_cnt_w(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Continuous repetition-count health test on the raw (pre-debias) bit stream.
// The sticky fail flag is set once a run of identical bits reaches RPT_LIMIT.
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int unsigned RPT_LIMIT = RPT_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,    // asynchronous, active-high
  input  logic bit_val,  // raw bit under test
  input  logic strobe,   // raw bit accepted this cycle
  input  logic clear,    // clears the sticky flag and the run counter
  output logic fail
);

  localparam int unsigned CntW = rep_cnt_w(RPT_LIMIT);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] Limit  = CntW'(RPT_LIMIT);

  logic            last_d, last_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            fail_d, fail_q;

  // Next-state: run tracking with saturation; clear wins over a same-edge bit.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    fail_d = fail_q;
    if (clear) begin
      fail_d = 1'b0;
      cnt_d  = '0;
      if (strobe) begin
        // The coinciding bit opens a fresh run.
        last_d = bit_val;
        cnt_d  = CntOne;
      end
    end else if (strobe) begin
      last_d = bit_val;
      // A zero count means no previous bit since reset or clear.
      if (cnt_q == '0 || bit_val != last_q) begin
        cnt_d = CntOne;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end
      if (cnt_d >= Limit) begin
        fail_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last_q <= 1'b0;
      cnt_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      fail_q <= fail_d;
    end
  end

  assign fail = fail_q;

endmodule

// File: rtl/trng_vn_packer.sv
// Von Neumann debiaser and MSB-first byte packer with a valid/ready output
// register, gated by a repetition-count health test on the raw stream.
module trng_vn_packer
  import trng_pkg::*;
#(
  parameter int unsigned RPT_LIMIT = RPT_LIMIT_DEF,
  parameter int unsigned OVF_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,        // asynchronous, active-high
  input  logic              enable,
  input  logic              raw_bit,
  input  logic              raw_valid,
  input  logic              clear_fail,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              health_fail,
  output logic [OVF_W-1:0]  overflow_cnt,
  output logic [2:0]        bits_pending
);

  localparam logic [OVF_W-1:0] OvfMax = '1;

  logic accept;      // raw bit accepted this cycle
  logic feed;        // accepted bit also goes to the debiaser
  logic emit_vld;    // debiaser produced a bit this cycle
  logic emit_bit;
  logic byte_done;   // packer completed a byte this cycle

  logic [BYTE_W-1:0] byte_nxt;

  logic              pair_d, pair_q;
  logic              first_d, first_q;
  logic [BYTE_W-2:0] shift_d, shift_q;
  logic [2:0]        pend_d, pend_q;
  logic [BYTE_W-1:0] out_d, out_q;
  logic              valid_d, valid_q;
  logic [OVF_W-1:0]  ovf_d, ovf_q;

  assign accept = raw_valid & enable;
  // A bit coinciding with clear_fail only restarts the health test.
  assign feed   = accept & ~health_fail & ~clear_fail;

  trng_rep_test #(
    .RPT_LIMIT (RPT_LIMIT)
  ) u_rep_test (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_val (raw_bit),
    .strobe  (accept),
    .clear   (clear_fail),
    .fail    (health_fail)
  );

  // Debiaser: pair up accepted bits; 10 -> 1, 01 -> 0, 00/11 -> nothing.
  always_comb begin
    pair_d   = pair_q;
    first_d  = first_q;
    emit_vld = 1'b0;
    emit_bit = 1'b0;
    if (!enable) begin
      // Pairs never straddle a disable gap.
      pair_d = 1'b0;
    end else if (feed) begin
      if (!pair_q) begin
        pair_d  = 1'b1;
        first_d = raw_bit;
      end else begin
        pair_d = 1'b0;
        case ({first_q, raw_bit})
          PAIR_ONE: begin
            emit_vld = 1'b1;
            emit_bit = 1'b1;
          end
          PAIR_ZERO: begin
            emit_vld = 1'b1;
            emit_bit = 1'b0;
          end
          default: ;
        endcase
      end
    end
    if (health_fail) begin
      pair_d = 1'b0;
    end
  end

  // Packer: shift emitted bits in at the LSB so the first bit lands in the MSB.
  always_comb begin
    shift_d   = shift_q;
    pend_d    = pend_q;
    byte_done = 1'b0;
    byte_nxt  = {shift_q, emit_bit};
    if (emit_vld) begin
      shift_d = byte_nxt[BYTE_W-2:0];
      if (pend_q == 3'd7) begin
        pend_d    = 3'd0;
        byte_done = 1'b1;
      end else begin
        pend_d = pend_q + 3'd1;
      end
    end
    // A failing source discards the partial byte.
    if (health_fail) begin
      pend_d = 3'd0;
    end
  end

  // Output register: handshake drain, same-edge reload, drop with saturating count.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && byte_ready) begin
      valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!valid_q || byte_ready) begin
        out_d   = byte_nxt;
        valid_d = 1'b1;
      end else if (ovf_q != OvfMax) begin
        ovf_d = ovf_q + OVF_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
      shift_q <= '0;
      pend_q  <= 3'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      pair_q  <= pair_d;
      first_q <= first_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_out     = out_q;
  assign byte_valid   = valid_q;
  assign overflow_cnt = ovf_q;
  assign bits_pending = pend_q;

endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed self-checking bench for trng_vn_packer.
module tb_trng_vn_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       raw_bit = 1'b0;
  logic       raw_valid = 1'b0;
  logic       clear_fail = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       health_fail;
  logic [7:0] overflow_cnt;
  logic [2:0] bits_pending;

  int n_checks = 0;
  int n_fail = 0;

  // Raw pairs with discard pairs 00/11 interleaved; survivors spell 0xB2.
  logic [1:0] mixed_pairs [12] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10,
                                   2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01};

  trng_vn_packer #(
    .RPT_LIMIT (32),
    .OVF_W     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .raw_bit      (raw_bit),
    .raw_valid    (raw_valid),
    .clear_fail   (clear_fail),
    .byte_ready   (byte_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .health_fail  (health_fail),
    .overflow_cnt (overflow_cnt),
    .bits_pending (bits_pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One accepted raw bit; returns 1 time unit after the sampling edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
  endtask

  task automatic send_pair(input logic e);
    if (e) begin
      send_bit(1'b1);
      send_bit(1'b0);
    end else begin
      send_bit(1'b0);
      send_bit(1'b1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_pair(b[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_fail = 1'b1;
    @(posedge clk);
    #1;
    clear_fail = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic [7:0] b;

    // Reset state.
    #12;
    check_eq("rst byte_out", byte_out, 8'h00);
    check_eq("rst byte_valid", byte_valid, 1'b0);
    check_eq("rst health_fail", health_fail, 1'b0);
    check_eq("rst overflow_cnt", overflow_cnt, 8'h00);
    check_eq("rst bits_pending", bits_pending, 3'd0);
    rst_n      = 1'b0;
    enable     = 1'b1;
    byte_ready = 1'b1;

    // Pack and handshake: 1,0,1,1,0,0,1,0 -> 0xB2.
    send_pair(1'b1);
    send_pair(1'b0);
    send_pair(1'b1);
    check_eq("pack pending3", bits_pending, 3'd3);
    send_pair(1'b1);
    send_pair(1'b0);
    send_pair(1'b0);
    send_pair(1'b1);
    send_pair(1'b0);
    check_eq("pack valid", byte_valid, 1'b1);
    check_eq("pack byte", byte_out, 8'hB2);
    check_eq("pack pending0", bits_pending, 3'd0);
    tick();
    check_eq("pack valid drop", byte_valid, 1'b0);

    // Discard pairs interleaved.
    for (int i = 0; i < 12; i++) begin
      send_bit(mixed_pairs[i][1]);
      send_bit(mixed_pairs[i][0]);
    end
    check_eq("discard valid", byte_valid, 1'b1);
    check_eq("discard byte", byte_out, 8'hB2);
    tick();

    // Disable gap breaks a pair: 1, gap, 0, 1 -> single 0 bit.
    send_bit(1'b1);
    check_eq("gap pending0", bits_pending, 3'd0);
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    check_eq("gap pending1", bits_pending, 3'd1);
    repeat (7) send_pair(1'b1);
    check_eq("gap byte", byte_out, 8'h7F);
    check_eq("gap valid", byte_valid, 1'b1);
    tick();

    // Backpressure and overflow.
    byte_ready = 1'b0;
    send_byte(8'hCA);
    check_eq("bp first valid", byte_valid, 1'b1);
    check_eq("bp first byte", byte_out, 8'hCA);
    send_byte(8'h35);
    check_eq("bp held byte", byte_out, 8'hCA);
    check_eq("bp held valid", byte_valid, 1'b1);
    check_eq("bp overflow", overflow_cnt, 8'd1);
    check_eq("bp pending0", bits_pending, 3'd0);
    b = 8'h5A;
    for (int i = 7; i >= 1; i--) send_pair(b[i]);
    send_bit(1'b0);
    byte_ready = 1'b1;
    send_bit(1'b1);
    check_eq("reload byte", byte_out, 8'h5A);
    check_eq("reload valid", byte_valid, 1'b1);
    check_eq("reload no drop", overflow_cnt, 8'd1);
    tick();
    check_eq("reload drained", byte_valid, 1'b0);

    // Health trip with a partial byte pending.
    repeat (5) send_pair(1'b1);
    check_eq("trip pending5", bits_pending, 3'd5);
    for (int i = 1; i <= 32; i++) begin
      send_bit(1'b1);
      if (i == 31) check_eq("trip before limit", health_fail, 1'b0);
    end
    check_eq("trip at limit", health_fail, 1'b1);
    tick();
    check_eq("trip partial cleared", bits_pending, 3'd0);
    repeat (10) send_pair(1'b1);
    check_eq("trip gated pending", bits_pending, 3'd0);
    check_eq("trip gated valid", byte_valid, 1'b0);
    check_eq("trip sticky", health_fail, 1'b1);
    pulse_clear();
    check_eq("clear fail", health_fail, 1'b0);
    check_eq("clear pending", bits_pending, 3'd0);
    send_byte(8'h3C);
    check_eq("resume byte", byte_out, 8'h3C);
    check_eq("resume valid", byte_valid, 1'b1);
    tick();

    // Clear coinciding with an accepted bit starts a new run of length 1.
    n = 0;
    while (health_fail !== 1'b1 && n < 40) begin
      send_bit(1'b1);
      n++;
    end
    check_eq("retrip", health_fail, 1'b1);
    @(negedge clk);
    clear_fail = 1'b1;
    raw_bit    = 1'b1;
    raw_valid  = 1'b1;
    @(posedge clk);
    #1;
    clear_fail = 1'b0;
    raw_valid  = 1'b0;
    check_eq("same-edge clear fail", health_fail, 1'b0);
    check_eq("same-edge clear pending", bits_pending, 3'd0);
    repeat (30) send_bit(1'b1);
    check_eq("run 31 no trip", health_fail, 1'b0);
    send_bit(1'b1);
    check_eq("run 32 trip", health_fail, 1'b1);
    pulse_clear();
    check_eq("second clear", health_fail, 1'b0);

    // Asynchronous reset with a held byte and 4 pending bits.
    byte_ready = 1'b0;
    send_byte(8'hE1);
    send_pair(1'b1);
    send_pair(1'b1);
    send_pair(1'b0);
    send_pair(1'b0);
    check_eq("pre-rst valid", byte_valid, 1'b1);
    check_eq("pre-rst pending", bits_pending, 3'd4);
    check_eq("pre-rst overflow", overflow_cnt, 8'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("async byte_out", byte_out, 8'h00);
    check_eq("async byte_valid", byte_valid, 1'b0);
    check_eq("async pending", bits_pending, 3'd0);
    check_eq("async overflow", overflow_cnt, 8'd0);
    check_eq("async health_fail", health_fail, 1'b0);
    rst_n      = 1'b0;
    byte_ready = 1'b1;
    send_byte(8'h96);
    check_eq("post-rst byte", byte_out, 8'h96);
    check_eq("post-rst valid", byte_valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_vn_packer.md
Name: trng_vn_packer

Overview:
Post-processing stage directly downstream of the ring-oscillator sampler (ro_buffer_counter). It consumes the sampled raw entropy bit stream and applies von Neumann debiasing. Surviving bits are packed MSB-first into bytes, which are presented on a valid/ready output. A continuous repetition-count health test on the raw stream gates output production when the source looks stuck.

Parameters:
RPT_LIMIT, 32, number of consecutive identical raw bits that trips the health test (range 2..255)
OVF_W, 8, width of the saturating dropped-byte counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-high; name kept for consistency with ro_buffer_counter
enable  input  1  1 = accept raw bits; 0 = raw_valid ignored
raw_bit  input  1  sampled RO bit
raw_valid  input  1  single-cycle strobe qualifying raw_bit
clear_fail  input  1  pulse; clears sticky health_fail and the repetition counter
byte_ready  input  1  consumer accepts byte_out this cycle
byte_out  output  8  packed random byte
byte_valid  output  1  byte_out holds an unconsumed byte
health_fail  output  1  sticky repetition-test failure flag
overflow_cnt  output  OVF_W  bytes dropped because the output register was full; saturates
bits_pending  output  3  debiased bits currently in the packer (0..7)

Behaviour:
- Reset (async, rst_n=1) clears all state: byte_out=0x00, byte_valid=0, health_fail=0, overflow_cnt=0, bits_pending=0, pair flag=0, repetition counter=0.
- Accepted raw bit: raw_valid=1 and enable=1. All state updates occur on the rising clk edge that samples the strobe.
- Debiaser uses a pair flag and a stored first bit.
  - First accepted bit of a pair: store it, set the flag.
  - Second accepted bit: clear the flag. Pair 10 emits 1; pair 01 emits 0; pairs 00 and 11 emit nothing.
- enable=0 clears the pair flag, so pairs never straddle a disable gap. Packer contents and bits_pending are retained.
- Packer: emitted bit shifts into the LSB and the shift register moves left, so the first emitted bit ends up at byte_out[7]. bits_pending increments and wraps 7->0 on the 8th bit.
- Byte completion on the 8th bit:
  - If byte_valid=0, or byte_valid=1 and byte_ready=1 in the same cycle: load byte_out and set byte_valid=1 on that same edge, so latency is 0 cycles after the completing strobe edge.
  - Otherwise drop the byte and increment overflow_cnt, saturating at all-ones.
- Output handshake: byte_valid=1 and byte_ready=1 consumes the byte; byte_valid falls next edge unless a reload happens on the same edge. byte_out is stable while byte_valid=1.
- Repetition test runs on every accepted raw bit, pre-debias.
  - rep_cnt resets to 1 when the bit differs from the previous accepted bit (or on the first bit after reset or clear); otherwise it increments, saturating.
  - When rep_cnt reaches RPT_LIMIT, health_fail sets on that edge.
- While health_fail=1:
  - Debiaser and packer ignore input; pair flag and bits_pending are forced to 0; partial byte is discarded.
  - A byte already in the output register remains drainable.
  - The repetition test keeps running.
- clear_fail=1: health_fail=0 and rep_cnt=0. If an accepted bit arrives on the same edge, clear_fail wins, and that bit starts a new run with rep_cnt=1 and is not fed to the debiaser.
- Reset mid-byte discards the partial byte and any held output byte immediately.

Decomposition:
- Package trng_pkg holds:
  - BYTE_W=8
  - default RPT_LIMIT
  - rep counter width function: $clog2(RPT_LIMIT+1)
  - pair-encoding constants PAIR_ONE=2'b10 and PAIR_ZERO=2'b01
- One sub-module, trng_rep_test: inputs clk, rst_n, bit, strobe, clear; output fail. It holds the last-bit register, the saturating counter and the sticky flag.
- Debiaser, packer and output register stay in trng_vn_packer.

Test Plan:
- Pack and handshake: byte_ready=1, raw pairs 10,01,10,10,01,01,10,01 -> byte_out=0xB2, byte_valid high for exactly 1 cycle, bits_pending back to 0.
- Discard and gap: pairs 00,11 interleaved with the pairs above -> still 0xB2. A single raw 1, then enable=0 for 3 cycles, then 01 -> emits 0 only (pair broken).
- Backpressure and overflow: byte_ready=0, feed 16 debiased bits -> first byte held unchanged, second dropped, overflow_cnt=1. Assert byte_ready with a 3rd byte completing on the same edge -> 3rd byte loaded, no drop.
- Health trip: 32 consecutive raw 1s -> health_fail rises on the 32nd strobe. A partial byte with 5 pending bits is cleared, and further 10 pairs produce nothing. Pulse clear_fail -> output resumes from bits_pending=0.
- Clear with same-edge bit: clear_fail coincides with a strobe -> health_fail=0, rep_cnt=1, bits_pending unchanged at 0.
- Async reset with byte_valid=1 and 4 pending bits: rst_n pulse mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
